// File: rtl/async_count_reader_if.sv
// Bus interface for async_count_reader: the rippling counter input, the
// read request and the coherent-count results. The slave modport is the
// reader's view; the master modport is the environment's view.
// Optional feature macro: ASYNC_RD_DELTA_EN adds the cnt_delta signal.
interface async_count_reader_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] cnt_in;
    logic             rd_req;
    logic             busy;
    logic [WIDTH-1:0] cnt_out;
    logic             cnt_valid;
    logic             err;
`ifdef ASYNC_RD_DELTA_EN
    logic [WIDTH-1:0] cnt_delta;

    modport slave (
        input  cnt_in,
        input  rd_req,
        output busy,
        output cnt_out,
        output cnt_valid,
        output err,
        output cnt_delta
    );

    modport master (
        output cnt_in,
        output rd_req,
        input  busy,
        input  cnt_out,
        input  cnt_valid,
        input  err,
        input  cnt_delta
    );
`else
    modport slave (
        input  cnt_in,
        input  rd_req,
        output busy,
        output cnt_out,
        output cnt_valid,
        output err
    );

    modport master (
        output cnt_in,
        output rd_req,
        input  busy,
        input  cnt_out,
        input  cnt_valid,
        input  err
    );
`endif
endinterface

// File: rtl/async_count_reader.sv
// async_count_reader: brings a free-running asynchronous ripple counter
// into the clk domain and, on request, returns a coherent count. A value
// is accepted only when two consecutive synchronised samples agree, so a
// sample taken while the counter is still rippling is never returned.
// A read that keeps seeing disagreeing samples gives up after MAX_RETRY
// compares and pulses err instead of cnt_valid.
// Optional feature macro: ASYNC_RD_DELTA_EN adds cnt_delta, the difference
// between the new count and the previously returned one (mod 2^WIDTH).
module async_count_reader #(
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    async_count_reader_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMP_A = 2'd1,
        CMP    = 2'd2
    } state_t;

    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] samp_a;
    logic [WIDTH-1:0] samp_a_nxt;
    logic [3:0]       retry;
    logic [3:0]       retry_nxt;
    logic [WIDTH-1:0] cnt_out_q;
    logic [WIDTH-1:0] cnt_out_nxt;
    logic             valid_q;
    logic             valid_nxt;
    logic             err_q;
    logic             err_nxt;
    logic             busy_q;

    // Two-flop synchroniser on the counter bus, free-running regardless of the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= bus.cnt_in;
            sync      <= sync_meta;
        end
    end

    // Read FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus next values of the sample, retry count and result outputs
    always_comb begin
        state_nxt   = state;
        samp_a_nxt  = samp_a;
        retry_nxt   = retry;
        cnt_out_nxt = cnt_out_q;
        valid_nxt   = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.rd_req) begin
                    state_nxt = SAMP_A;
                    retry_nxt = 4'd0;
                end
            end
            SAMP_A: begin
                samp_a_nxt = sync;
                state_nxt  = CMP;
            end
            CMP: begin
                if (sync == samp_a) begin
                    cnt_out_nxt = sync;
                    valid_nxt   = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    samp_a_nxt = sync;
                    retry_nxt  = retry + 4'd1;
                    if (retry_nxt == RETRY_LIMIT) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and output registers; busy is registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_a    <= '0;
            retry     <= 4'd0;
            cnt_out_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            samp_a    <= samp_a_nxt;
            retry     <= retry_nxt;
            cnt_out_q <= cnt_out_nxt;
            valid_q   <= valid_nxt;
            err_q     <= err_nxt;
            busy_q    <= (state_nxt != IDLE);
        end
    end

    assign bus.busy      = busy_q;
    assign bus.cnt_out   = cnt_out_q;
    assign bus.cnt_valid = valid_q;
    assign bus.err       = err_q;

`ifdef ASYNC_RD_DELTA_EN
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] delta_q;

    // On each accepted count, record the step from the previous accepted count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev    <= '0;
            delta_q <= '0;
        end else if (valid_nxt) begin
            delta_q <= sync - prev;
            prev    <= sync;
        end
    end

    assign bus.cnt_delta = delta_q;
`endif

endmodule

// File: tb/tb_async_count_reader.sv
// Testbench for async_count_reader. Each segment pre-builds a per-edge
// table of cnt_in and rd_req, derives the expected outputs from a
// transaction-level model (a read accepted at edge k compares synchronised
// samples pairwise from edge k+2 on, at most MAX_RETRY times), then plays
// the table into the DUT and compares every output after every edge.
module tb_async_count_reader;

    localparam int WIDTH     = 8;
    localparam int MAX_RETRY = 4;
    localparam int MAXLEN    = 64;

    logic clk;
    logic rst_n;

    async_count_reader_if #(.WIDTH(WIDTH)) bus ();

    async_count_reader #(
        .WIDTH     (WIDTH),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int check_count = 0;
    int error_count = 0;

    logic [WIDTH-1:0] cin_arr   [MAXLEN];
    bit               rd_arr    [MAXLEN];
    bit               exp_busy  [MAXLEN];
    bit               exp_valid [MAXLEN];
    bit               exp_err   [MAXLEN];
    logic [WIDTH-1:0] exp_out   [MAXLEN];
    logic [WIDTH-1:0] exp_delta [MAXLEN];

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        check_count++;
        if (got !== expv) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
        end
    endtask

    // Value the synchronised bus shows just before edge e (reset clears it)
    function automatic logic [WIDTH-1:0] syncAt(input int e);
        if (e < 2 || e - 2 >= MAXLEN) return '0;
        return cin_arr[e - 2];
    endfunction

    // Transaction model: when each read ends, how, and with which value
    task automatic computeExpected(input int len);
        int               last_end;
        int               e;
        bit               done;
        bit               ev_valid [MAXLEN];
        logic [WIDTH-1:0] ev_val   [MAXLEN];
        logic [WIDTH-1:0] cur;
        logic [WIDTH-1:0] dlt;
        for (int n = 0; n < MAXLEN; n++) begin
            exp_busy[n]  = 1'b0;
            exp_valid[n] = 1'b0;
            exp_err[n]   = 1'b0;
            ev_valid[n]  = 1'b0;
            ev_val[n]    = '0;
        end
        last_end = -1;
        for (int k = 0; k < len; k++) begin
            if (rd_arr[k] && k > last_end) begin
                done = 1'b0;
                for (int j = 1; j <= MAX_RETRY && !done; j++) begin
                    e = k + 1 + j;
                    if (syncAt(e) == syncAt(e - 1)) begin
                        ev_valid[e] = 1'b1;
                        ev_val[e]   = syncAt(e);
                        last_end    = e;
                        done        = 1'b1;
                    end
                end
                if (!done) begin
                    last_end = k + 1 + MAX_RETRY;
                    exp_err[last_end] = 1'b1;
                end
                for (int m = k; m < last_end; m++) exp_busy[m] = 1'b1;
            end
        end
        cur = '0;
        dlt = '0;
        for (int n = 0; n < MAXLEN; n++) begin
            if (ev_valid[n]) begin
                dlt = ev_val[n] - cur;
                cur = ev_val[n];
                exp_valid[n] = 1'b1;
            end
            exp_out[n]   = cur;
            exp_delta[n] = dlt;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " busy"},      32'(bus.busy),      32'd0);
        checkOutput({tag, " cnt_valid"}, 32'(bus.cnt_valid), 32'd0);
        checkOutput({tag, " err"},       32'(bus.err),       32'd0);
        checkOutput({tag, " cnt_out"},   32'(bus.cnt_out),   32'd0);
`ifdef ASYNC_RD_DELTA_EN
        checkOutput({tag, " cnt_delta"}, 32'(bus.cnt_delta), 32'd0);
`endif
    endtask

    // Reset, then play the table edge by edge; optionally reset mid-run at abort_edge
    task automatic applyStimulus(input string name, input int len, input int abort_edge);
        string tag;
        for (int n = len - 8; n < MAXLEN; n++) if (n >= 0) rd_arr[n] = 1'b0;
        computeExpected(len);
        rst_n       = 1'b0;
        bus.cnt_in  = '0;
        bus.rd_req  = 1'b0;
        repeat (2) @(negedge clk);
        checkAllZero({name, " reset"});
        rst_n = 1'b1;
        for (int n = 0; n < len; n++) begin
            bus.cnt_in = cin_arr[n];
            bus.rd_req = rd_arr[n];
            @(posedge clk);
            #1;
            tag = $sformatf("%s@%0d", name, n);
            checkOutput({tag, " busy"},      32'(bus.busy),      32'(exp_busy[n]));
            checkOutput({tag, " cnt_valid"}, 32'(bus.cnt_valid), 32'(exp_valid[n]));
            checkOutput({tag, " err"},       32'(bus.err),       32'(exp_err[n]));
            checkOutput({tag, " cnt_out"},   32'(bus.cnt_out),   32'(exp_out[n]));
`ifdef ASYNC_RD_DELTA_EN
            checkOutput({tag, " cnt_delta"}, 32'(bus.cnt_delta), 32'(exp_delta[n]));
`endif
            @(negedge clk);
            if (n == abort_edge) begin
                rst_n = 1'b0;
                #1;
                checkAllZero({tag, " midreset"});
                bus.rd_req = 1'b0;
                return;
            end
        end
        bus.rd_req = 1'b0;
    endtask

    task automatic clearTable();
        for (int n = 0; n < MAXLEN; n++) begin
            cin_arr[n] = '0;
            rd_arr[n]  = 1'b0;
        end
    endtask

    initial begin
        int chg_pct [3];
        logic [WIDTH-1:0] cur;
        rst_n      = 1'b0;
        bus.cnt_in = '0;
        bus.rd_req = 1'b0;

        // Static read: value held long before the request
        clearTable();
        for (int n = 0; n < 24; n++) cin_arr[n] = 8'h3C;
        rd_arr[3] = 1'b1;
        applyStimulus("static", 24, -1);

        // Reset one cycle into a read, after an earlier successful read
        clearTable();
        for (int n = 0; n < 24; n++) cin_arr[n] = 8'h5A;
        rd_arr[3] = 1'b1;
        rd_arr[7] = 1'b1;
        applyStimulus("rstmid", 24, 8);
        // Fresh read after reset release returns the same static value
        clearTable();
        for (int n = 0; n < 24; n++) cin_arr[n] = 8'h5A;
        rd_arr[3] = 1'b1;
        applyStimulus("postrst", 24, -1);

        // Counter steps 07->08 between the first sample and the compare
        clearTable();
        for (int n = 0; n < 24; n++) cin_arr[n] = (n < 4) ? 8'h07 : 8'h08;
        rd_arr[4] = 1'b1;
        applyStimulus("midchg", 24, -1);

        // Retry exhaustion: a good read, then a counter toggling every cycle
        clearTable();
        for (int n = 0; n < 24; n++) cin_arr[n] = (n < 7) ? 8'h33 : ((n % 2) ? 8'h55 : 8'hAA);
        rd_arr[3] = 1'b1;
        rd_arr[8] = 1'b1;
        applyStimulus("exhaust", 24, -1);

        // Wrap-around between two reads: FE then 03
        clearTable();
        for (int n = 0; n < 24; n++) cin_arr[n] = (n < 6) ? 8'hFE : 8'h03;
        rd_arr[3] = 1'b1;
        rd_arr[9] = 1'b1;
        applyStimulus("wrap", 24, -1);

        // Request held high for 10 cycles: back-to-back reads, extras ignored
        clearTable();
        for (int n = 0; n < 24; n++) cin_arr[n] = 8'hA1;
        for (int n = 3; n < 13; n++) rd_arr[n] = 1'b1;
        applyStimulus("b2b", 24, -1);

        // Randomised segments with slow, medium and fast counter activity
        chg_pct[0] = 5;
        chg_pct[1] = 35;
        chg_pct[2] = 85;
        for (int s = 0; s < 3; s++) begin
            clearTable();
            cur = 8'($urandom);
            for (int n = 0; n < MAXLEN; n++) begin
                if ($urandom_range(0, 99) < chg_pct[s]) cur = 8'($urandom);
                cin_arr[n] = cur;
                rd_arr[n]  = ($urandom_range(0, 99) < 40);
            end
            applyStimulus($sformatf("rand%0d", s), MAXLEN, -1);
        end

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule

// File: doc/async_count_reader.md
# async_count_reader

Clock-domain reader for the free-running asynchronous ripple counter. It synchronises the counter's rippling output bus into the `clk` domain and, on request, returns a coherent count. A value is accepted only when two consecutive synchronised samples agree, which rejects mid-ripple values. It sits between the ripple counter chain and any synchronous consumer, such as a frequency meter or event logger.

## Interface
- `WIDTH`, 8: width of the ripple counter bus.
- `MAX_RETRY`, 4: mismatching compare cycles tolerated before a read aborts; range 1..15.
- `clk  input  1`: system clock; all state updates on its rising edge.
- `rst_n  input  1`: asynchronous, active-low reset.
- `cnt_in  input  WIDTH`: ripple counter outputs; asynchronous to `clk` and may be mid-ripple.
- `rd_req  input  1`: read request, level-sampled; only acted on in IDLE.
- `busy  output  1`: read in progress (state is not IDLE).
- `cnt_out  output  WIDTH`: last coherent count; holds until the next successful read.
- `cnt_valid  output  1`: one-cycle pulse when `cnt_out` is updated.
- `err  output  1`: one-cycle pulse when a read aborts after `MAX_RETRY` mismatches.
- `cnt_delta  output  WIDTH`: present only with `ASYNC_RD_DELTA_EN`; `cnt_out` minus the previous `cnt_out`, modulo 2^WIDTH.

## Operation
- **Synchroniser:** two flops per bit on `cnt_in`, producing `sync` (2-cycle transport delay). The synchroniser runs continuously, independent of the FSM.
- **IDLE:**
  - `rd_req`=1 → SAMP_A and clear the retry counter.
  - `rd_req`=0 → stay.
- **SAMP_A:** capture `A <= sync`, then go to CMP.
- **CMP:**
  - If `sync == A`: load `cnt_out <= sync`, pulse `cnt_valid`, go to IDLE.
  - If not equal: `A <= sync` and retry counter +1. Once the counter reaches `MAX_RETRY`, pulse `err`, leave `cnt_out` unchanged, and go to IDLE. Otherwise stay in CMP.
- **Request handling:** `rd_req` is ignored while busy; no request queue. A `rd_req` held high issues back-to-back reads, each starting in the cycle after return to IDLE.
- **Mutual exclusion:** `cnt_valid` and `err` are never high in the same cycle.
- **Wrap-around:** a counter rolling from all-ones to zero is a normal value; `cnt_delta` wraps modulo 2^WIDTH.
- **Reset values** (asynchronous, at any point including mid-read): state IDLE, sync flops 0, `A` 0, retry counter 0, `cnt_out` 0, `cnt_valid` 0, `err` 0, `busy` 0, `cnt_delta` 0. An in-flight read is discarded with no pulse.

## Timing
- All outputs are registered.
- **Best-case read:** `rd_req` sampled high at edge 0 → `busy` high after edge 0 → `cnt_valid` and new `cnt_out` visible after edge 2. `busy` drops after edge 2, in the same cycle `cnt_valid` is high.
- **Retries:** each mismatch adds one cycle. Worst case, `err` is visible after edge 1+`MAX_RETRY`.
- **Value freshness:** the returned count reflects `cnt_in` as of at least 2 cycles before the accepting edge.
- **Ripple constraint:** the ripple counter's input event rate must leave the counter stable for at least 2 consecutive `clk` samples. Otherwise `err` is the expected outcome, not a bug.

## Configuration
- **`ASYNC_RD_DELTA_EN` defined:**
  - Adds a `prev` register and the `cnt_delta` output port.
  - On each `cnt_valid`: `cnt_delta <= sync - cnt_out` and `prev` is updated.
  - `err` leaves `cnt_delta` unchanged.
- **`ASYNC_RD_DELTA_EN` undefined:** the `cnt_delta` port and its logic are absent; all other behaviour is identical.

## Test plan
- **Reset mid-read:** static `cnt_in`=8'h5A; assert `rst_n`=0 one cycle after `rd_req` is accepted → all outputs 0 and state IDLE. After release, a new `rd_req` returns 8'h5A with no `err`.
- **Static read:** `cnt_in`=8'h3C held for ≥3 cycles, one-cycle `rd_req` at edge 0 → `busy` for edges 1–2, `cnt_valid`=1 and `cnt_out`=8'h3C after edge 2.
- **Mid-read change:** `cnt_in` changes 8'h07→8'h08 landing on `sync` between SAMP_A and CMP, then stays stable → one retry, then `cnt_out`=8'h08 with `cnt_valid` after edge 3.
- **Retry exhaustion:** `MAX_RETRY`=4 and `cnt_in` toggled every `clk` cycle → `err` pulses once after edge 5. `cnt_out` keeps its previous value and `cnt_valid` stays 0.
- **Wrap delta (`ASYNC_RD_DELTA_EN`):** read 8'hFE, then the counter advances to 8'h03, read again → `cnt_out`=8'h03, `cnt_delta`=8'h05.
- **Back-to-back and ignored requests:** `rd_req` held high for 10 cycles with static `cnt_in`=8'hA1 → `cnt_valid` pulses every 3 cycles. Requests arriving while `busy` produce no extra reads.
